reg_loader: RTL and testbench

Serial-to-register-bank loader that sits directly upstream of the 16-bit enabled registers in the register bank. It accepts a byte stream over a valid/ready handshake, assembles 4-byte frames (header, data high, data low, checksum), verifies them, and drives the shared 16-bit write-data bus plus a one-hot write-enable vector with one register enable bit per register. Malformed, out-of-range, or stalled frames are discarded and flagged without touching any register.

---
 rtl/reg_loader_pkg.sv | 31 +++
 rtl/reg_loader_if.sv | 24 ++
 rtl/reg_loader_timer.sv | 28 ++
 rtl/reg_loader.sv | 123 ++++++++++++
 tb/tb_reg_loader.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/reg_loader_pkg.sv
// Shared types and constants for the byte-stream register loader.
package reg_loader_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 4;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        GOT_HDR = 3'd1,
        GOT_HI  = 3'd2,
        GOT_LO  = 3'd3,
        WRITE   = 3'd4
    } state_t;

    // Fields of a frame collected before the checksum byte arrives
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } frame_t;

    function automatic logic is_sync(input logic [BYTE_W-1:0] b);
        return b[7:4] == SYNC_NIBBLE;
    endfunction

endpackage

// File: rtl/reg_loader_if.sv
// Byte-stream input and register write bus of the loader.
// The loader takes the slave side; the byte source / observer takes master.
interface reg_loader_if #(
    parameter int unsigned NREG = 8
);
    logic [reg_loader_pkg::BYTE_W-1:0] in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [reg_loader_pkg::DATA_W-1:0] wr_data;
    logic [NREG-1:0]                   wr_en;
    logic                              frame_ok;
    logic                              frame_err;
    logic                              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_data, wr_en, frame_ok, frame_err, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_data, wr_en, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/reg_loader_timer.sv
// Inter-byte timeout counter for frames in flight.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flags the edge on which the count would reach its limit; a clear on that edge wins
    assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/reg_loader.sv
// Assembles 4-byte frames from a byte stream, verifies them and strobes
// one register of the bank with the 16-bit payload.
module reg_loader
    import reg_loader_pkg::*;
#(
    parameter int unsigned NREG    = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    reg_loader_if.slave bus
);
    state_t              state, state_d;
    frame_t              frame_q, frame_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0]     wr_en_q, wr_en_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;
    logic                in_ready;
    logic                accept;
    logic                run;
    logic                expired;
    logic                chk_good;
    logic                addr_ok;

    assign in_ready = (state != WRITE);
    assign accept   = bus.in_valid && in_ready;
    assign run      = (state == GOT_HDR) || (state == GOT_HI) || (state == GOT_LO);

    assign chk_good = (({SYNC_NIBBLE, frame_q.addr} ^ frame_q.hi ^ frame_q.lo ^ bus.in_data)
                       == 8'h00);
    assign addr_ok  = ({1'b0, frame_q.addr} < 5'(NREG));

    frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || !run),
        .run     (run),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_q   <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            frame_q   <= frame_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        frame_d   = frame_q;
        wr_data_d = wr_data_q;
        wr_en_d   = '0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        unique case (state)
            IDLE: begin
                // Non-sync bytes are swallowed without a flag
                if (accept && is_sync(bus.in_data)) begin
                    frame_d.addr = bus.in_data[3:0];
                    state_d      = GOT_HDR;
                end
            end
            GOT_HDR: begin
                if (accept) begin
                    frame_d.hi = bus.in_data;
                    state_d    = GOT_HI;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GOT_HI: begin
                if (accept) begin
                    frame_d.lo = bus.in_data;
                    state_d    = GOT_LO;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GOT_LO: begin
                if (accept) begin
                    if (chk_good && addr_ok) begin
                        wr_data_d = {frame_q.hi, frame_q.lo};
                        for (int unsigned i = 0; i < NREG; i++) begin
                            wr_en_d[i] = (frame_q.addr == 4'(i));
                        end
                        ok_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_reg_loader.sv
// Directed bench for reg_loader: per-cycle vector table plus timeout and range sequences.
module tb_reg_loader;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        chk;
        logic        rdy;
        logic [7:0]  en;
        logic [15:0] data;
        logic        ok;
        logic        err;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    vec_t tbl[$];

    reg_loader_if #(.NREG(8)) if8 ();
    reg_loader_if #(.NREG(6)) if6 ();

    reg_loader #(.NREG(8), .TIMEOUT(16)) dut8 (.clk(clk), .reset(reset), .bus(if8));
    reg_loader #(.NREG(6), .TIMEOUT(16)) dut6 (.clk(clk), .reset(reset), .bus(if6));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                                input logic chk, input logic rdy, input logic [7:0] en,
                                input logic [15:0] data, input logic ok, input logic err,
                                input logic busy);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.chk = chk; r.rdy = rdy; r.en = en;
        r.data = data; r.ok = ok; r.err = err; r.busy = busy;
        return r;
    endfunction

    function automatic logic [27:0] pk(input logic rdy, input logic [7:0] en,
                                       input logic [15:0] data, input logic ok,
                                       input logic err, input logic busy);
        return {rdy, en, data, ok, err, busy};
    endfunction

    function automatic logic [27:0] obs8();
        return {if8.in_ready, if8.wr_en, if8.wr_data, if8.frame_ok, if8.frame_err, if8.busy};
    endfunction

    function automatic logic [27:0] obs6();
        return {if6.in_ready, 2'b00, if6.wr_en, if6.wr_data, if6.frame_ok, if6.frame_err,
                if6.busy};
    endfunction

    task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got rdy/en/data/ok/err/busy=%h, expected %h (t=%0t)",
                     name, got, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        reset        = r;
        if8.in_valid = v;
        if8.in_data  = d;
        if6.in_valid = v;
        if6.in_data  = d;
    endtask

    // Check the current cycle's outputs, then present this cycle's inputs
    task automatic tick(input string name, input logic v, input logic [7:0] d,
                        input logic [27:0] exp);
        @(negedge clk);
        check(name, obs8(), exp);
        drive(1'b0, v, d);
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00);

        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 0));
        // good frame, valid held high
        tbl.push_back(mk(0, 1, 8'hA3, 1, 1, 8'h00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h34, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h85, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h08, 16'h1234, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        // bad checksum
        tbl.push_back(mk(0, 1, 8'hA3, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h34, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h86, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 16'h1234, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        // junk bytes, then a frame to register 0 (A0^BE^EF^F1 == 0)
        tbl.push_back(mk(0, 1, 8'h53, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA0, 1, 1, 8'h00, 16'h1234, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hBE, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hEF, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hF1, 1, 1, 8'h00, 16'h1234, 0, 0, 1));
        // next header held through the WRITE stall
        tbl.push_back(mk(0, 1, 8'hA1, 1, 0, 8'h01, 16'hBEEF, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'hA1, 1, 1, 8'h00, 16'hBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 1, 1, 8'h00, 16'hBEEF, 0, 0, 1));
        // reset mid-frame, then the full frame
        tbl.push_back(mk(1, 1, 8'h33, 1, 1, 8'h00, 16'hBEEF, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hA1, 1, 1, 8'h00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h33, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hB0, 1, 1, 8'h00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h02, 16'h2233, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h00, 16'h2233, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].chk)
                check($sformatf("vec%0d", i), obs8(),
                      pk(tbl[i].rdy, tbl[i].en, tbl[i].data, tbl[i].ok, tbl[i].err,
                         tbl[i].busy));
            drive(tbl[i].rst, tbl[i].v, tbl[i].d);
        end

        // timeout: A2, 55, then silence
        tick("to_hdr", 1'b1, 8'hA2, pk(1, 8'h00, 16'h2233, 0, 0, 0));
        tick("to_hi",  1'b1, 8'h55, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        for (int k = 1; k <= 15; k++)
            tick($sformatf("to_wait%0d", k), 1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("to_err",   1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 1, 0));
        tick("to_after", 1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 0, 0));

        // byte on the last allowed cycle continues the frame (A2^55^66^91 == 0)
        tick("late_hdr", 1'b1, 8'hA2, pk(1, 8'h00, 16'h2233, 0, 0, 0));
        tick("late_hi",  1'b1, 8'h55, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        for (int k = 1; k <= 14; k++)
            tick($sformatf("late_wait%0d", k), 1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("late_lo",   1'b1, 8'h66, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("late_noto", 1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("late_gap",  1'b0, 8'h00, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("late_chk",  1'b1, 8'h91, pk(1, 8'h00, 16'h2233, 0, 0, 1));
        tick("late_wr",   1'b0, 8'h00, pk(0, 8'h04, 16'h5566, 1, 0, 1));
        tick("late_done", 1'b0, 8'h00, pk(1, 8'h00, 16'h5566, 0, 0, 0));

        // address 7: in range for 8 registers, out of range for 6
        tick("rng_hdr", 1'b1, 8'hA7, pk(1, 8'h00, 16'h5566, 0, 0, 0));
        tick("rng_hi",  1'b1, 8'h00, pk(1, 8'h00, 16'h5566, 0, 0, 1));
        tick("rng_lo",  1'b1, 8'h01, pk(1, 8'h00, 16'h5566, 0, 0, 1));
        tick("rng_chk", 1'b1, 8'hA6, pk(1, 8'h00, 16'h5566, 0, 0, 1));
        @(negedge clk);
        check("rng_wr8",  obs8(), pk(0, 8'h80, 16'h0001, 1, 0, 1));
        check("rng_err6", obs6(), pk(1, 8'h00, 16'h5566, 0, 1, 0));
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("rng_idle8", obs8(), pk(1, 8'h00, 16'h0001, 0, 0, 0));
        check("rng_idle6", obs6(), pk(1, 8'h00, 16'h5566, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
